// File: rtl/cam_match_resolver_if.sv
// cam_match_resolver_if: stream and status bundle between the CAM match
// decoder (master side), the address consumer and cam_match_resolver
// (slave side). Optional count ports exist only when CAM_MATCH_COUNT_EN
// is defined.
interface cam_match_resolver_if #(
  parameter int CAM_DEPTH = 8,
  parameter int ADDR_W    = 3
);
  logic [CAM_DEPTH-1:0] match_vec;
  logic                 match_valid;
  logic                 match_ready;
  logic [ADDR_W-1:0]    addr_out;
  logic                 addr_valid;
  logic                 addr_ready;
  logic                 match_found;
  logic                 multi_match;
  logic                 done;
`ifdef CAM_MATCH_COUNT_EN
  logic [ADDR_W:0]      match_count;
  logic [ADDR_W:0]      remaining;
`endif

  modport master (
    output match_vec, match_valid, addr_ready,
    input  match_ready, addr_out, addr_valid, match_found, multi_match, done
`ifdef CAM_MATCH_COUNT_EN
    , input match_count, remaining
`endif
  );

  modport slave (
    input  match_vec, match_valid, addr_ready,
    output match_ready, addr_out, addr_valid, match_found, multi_match, done
`ifdef CAM_MATCH_COUNT_EN
    , output match_count, remaining
`endif
  );
endinterface

// File: rtl/cam_match_resolver.sv
// cam_match_resolver: captures a multi-hot CAM match vector and streams the
// index of every set bit, lowest first, over a valid/ready handshake, then
// pulses done. Optional feature macro: CAM_MATCH_COUNT_EN adds match_count
// (popcount at accept) and remaining (addresses still to be delivered).
module cam_match_resolver #(
  parameter int CAM_DEPTH = 8,
  parameter int ADDR_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  cam_match_resolver_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [CAM_DEPTH-1:0] pending_r;
  logic [ADDR_W-1:0]    addr_r;
  logic                 addr_valid_r;
  logic                 match_ready_r;
  logic                 done_r;
  logic                 found_r;
  logic                 multi_r;
  logic                 handshake_s;
  logic [CAM_DEPTH-1:0] pending_clr_s;
  logic                 vec_multi_s;
`ifdef CAM_MATCH_COUNT_EN
  logic [ADDR_W:0]      count_r;
  logic [ADDR_W:0]      remaining_r;
`endif

  // Index of the lowest set bit; scanning downward lets the lowest win.
  function automatic logic [ADDR_W-1:0] lowest_index(input logic [CAM_DEPTH-1:0] v);
    logic [ADDR_W-1:0] idx;
    idx = {ADDR_W{1'b0}};
    for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = ADDR_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

`ifdef CAM_MATCH_COUNT_EN
  // Number of set bits in a match vector.
  function automatic logic [ADDR_W:0] popcount(input logic [CAM_DEPTH-1:0] v);
    logic [ADDR_W:0] n;
    n = {(ADDR_W + 1){1'b0}};
    for (int i = 0; i < CAM_DEPTH; i++) begin
      n = n + {{ADDR_W{1'b0}}, v[i]};
    end
    return n;
  endfunction
`endif

  // Handshake detect, lowest-bit clear and two-or-more detection without a popcount.
  always_comb begin
    handshake_s   = addr_valid_r & bus.addr_ready;
    pending_clr_s = pending_r & (pending_r - CAM_DEPTH'(1));
    vec_multi_s   = |(bus.match_vec & (bus.match_vec - CAM_DEPTH'(1)));
  end

  // Resolver FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      pending_r     <= {CAM_DEPTH{1'b0}};
      addr_r        <= {ADDR_W{1'b0}};
      addr_valid_r  <= 1'b0;
      match_ready_r <= 1'b1;
      done_r        <= 1'b0;
      found_r       <= 1'b0;
      multi_r       <= 1'b0;
`ifdef CAM_MATCH_COUNT_EN
      count_r       <= {(ADDR_W + 1){1'b0}};
      remaining_r   <= {(ADDR_W + 1){1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.match_valid) begin
            pending_r     <= bus.match_vec;
            found_r       <= |bus.match_vec;
            multi_r       <= vec_multi_s;
            addr_r        <= lowest_index(bus.match_vec);
            match_ready_r <= 1'b0;
`ifdef CAM_MATCH_COUNT_EN
            count_r       <= popcount(bus.match_vec);
            remaining_r   <= popcount(bus.match_vec);
`endif
            if (|bus.match_vec) begin
              state_r      <= SCAN;
              addr_valid_r <= 1'b1;
            end else begin
              state_r      <= DONE;
              done_r       <= 1'b1;
            end
          end else begin
            match_ready_r <= 1'b1;
          end
        end
        SCAN: begin
          if (handshake_s) begin
            pending_r <= pending_clr_s;
`ifdef CAM_MATCH_COUNT_EN
            remaining_r <= remaining_r - {{ADDR_W{1'b0}}, 1'b1};
`endif
            if (pending_clr_s == {CAM_DEPTH{1'b0}}) begin
              state_r      <= DONE;
              addr_valid_r <= 1'b0;
              done_r       <= 1'b1;
            end else begin
              addr_r       <= lowest_index(pending_clr_s);
            end
          end else begin
            addr_valid_r <= 1'b1;
          end
        end
        DONE: begin
          state_r       <= IDLE;
          done_r        <= 1'b0;
          addr_valid_r  <= 1'b0;
          match_ready_r <= 1'b1;
        end
        default: begin
          // Unreachable encoding: recover to a clean idle without a done pulse.
          state_r       <= IDLE;
          pending_r     <= {CAM_DEPTH{1'b0}};
          addr_valid_r  <= 1'b0;
          done_r        <= 1'b0;
          match_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.match_ready = match_ready_r;
  assign bus.addr_out    = addr_r;
  assign bus.addr_valid  = addr_valid_r;
  assign bus.match_found = found_r;
  assign bus.multi_match = multi_r;
  assign bus.done        = done_r;
`ifdef CAM_MATCH_COUNT_EN
  assign bus.match_count = count_r;
  assign bus.remaining   = remaining_r;
`endif

endmodule

// File: tb/tb_cam_match_resolver.sv
// tb_cam_match_resolver: table-driven and randomized self-checking bench for
// cam_match_resolver. The reference model lists the set bits of each vector
// in ascending order and expects them in sequence, then a done pulse.
module tb_cam_match_resolver;
  localparam int CAM_DEPTH = 8;
  localparam int ADDR_W    = 3;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  cam_match_resolver_if #(.CAM_DEPTH(CAM_DEPTH), .ADDR_W(ADDR_W)) bus ();

  cam_match_resolver #(.CAM_DEPTH(CAM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] vec;
    int         exp_n;
    bit         exp_found;
    bit         exp_multi;
    int         exp_first;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!bus.match_ready && k < 20) begin
      step();
      k++;
    end
    chk("wait_idle", int'(bus.match_ready), 1);
  endtask

  // Present one vector, drain it with addr_ready high ready_pct percent of cycles.
  task automatic run_vector(input logic [7:0] vec, input int ready_pct,
                            output int first, output int naddr, output int cycles);
    int q[$];
    int total;
    bit finished;
    bit hs;
    first = -1;
    naddr = 0;
    cycles = 0;
    wait_idle();
    for (int i = 0; i < CAM_DEPTH; i++) if (vec[i]) q.push_back(i);
    total = q.size();
    bus.match_vec   = vec;
    bus.match_valid = 1'b1;
    step();
    // Garbage while busy must be ignored.
    bus.match_valid = 1'($urandom_range(0, 1));
    bus.match_vec   = 8'($urandom);
    finished = 1'b0;
    for (int c = 0; c < 60 && !finished; c++) begin
      cycles++;
      chk("match_ready_busy", int'(bus.match_ready), 0);
      chk("match_found", int'(bus.match_found), (total > 0) ? 1 : 0);
      chk("multi_match", int'(bus.multi_match), (total >= 2) ? 1 : 0);
`ifdef CAM_MATCH_COUNT_EN
      chk("match_count", int'(bus.match_count), total);
      chk("remaining", int'(bus.remaining), q.size());
`endif
      if (q.size() > 0) begin
        chk("addr_valid", int'(bus.addr_valid), 1);
        chk("addr_out", int'(bus.addr_out), q[0]);
        chk("done_early", int'(bus.done), 0);
        if (first < 0) first = int'(bus.addr_out);
        hs = ($urandom_range(1, 100) <= ready_pct);
        bus.addr_ready = hs;
        step();
        if (hs) begin
          void'(q.pop_front());
          naddr++;
        end
      end else begin
        chk("done_pulse", int'(bus.done), 1);
        chk("addr_valid_done", int'(bus.addr_valid), 0);
        finished = 1'b1;
        bus.addr_ready = 1'($urandom_range(0, 1));
        step();
      end
    end
    if (!finished) chk("drain_timeout", 0, 1);
    bus.match_valid = 1'b0;
    chk("idle_match_ready", int'(bus.match_ready), 1);
    chk("done_one_cycle", int'(bus.done), 0);
    chk("idle_addr_valid", int'(bus.addr_valid), 0);
  endtask

  initial begin
    int first, naddr, cycles;
    n_checks = 0;
    n_fail   = 0;
    tbl[0] = '{8'b0010_0000, 1, 1'b1, 1'b0, 5};
    tbl[1] = '{8'b1000_1010, 3, 1'b1, 1'b1, 1};
    tbl[2] = '{8'b0000_0110, 2, 1'b1, 1'b1, 1};
    tbl[3] = '{8'b0000_0000, 0, 1'b0, 1'b0, -1};
    tbl[4] = '{8'b1111_1111, 8, 1'b1, 1'b1, 0};
    tbl[5] = '{8'b1000_0000, 1, 1'b1, 1'b0, 7};
    tbl[6] = '{8'b0101_0101, 4, 1'b1, 1'b1, 0};
    tbl[7] = '{8'b0000_0001, 1, 1'b1, 1'b0, 0};

    rst = 1'b1;
    bus.match_vec   = 8'h00;
    bus.match_valid = 1'b0;
    bus.addr_ready  = 1'b0;
    #3;
    chk("rst_addr_valid", int'(bus.addr_valid), 0);
    chk("rst_addr_out", int'(bus.addr_out), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_found", int'(bus.match_found), 0);
    chk("rst_multi", int'(bus.multi_match), 0);
`ifdef CAM_MATCH_COUNT_EN
    chk("rst_count", int'(bus.match_count), 0);
`endif
    #9 rst = 1'b0;
    step();
    chk("rst_match_ready", int'(bus.match_ready), 1);

    // Table: full-rate drain, N addresses in N SCAN cycles plus DONE.
    for (int t = 0; t < 8; t++) begin
      run_vector(tbl[t].vec, 100, first, naddr, cycles);
      chk("tbl_first", first, tbl[t].exp_first);
      chk("tbl_naddr", naddr, tbl[t].exp_n);
      chk("tbl_cycles", cycles, tbl[t].exp_n + 1);
      chk("tbl_found_hold", int'(bus.match_found), int'(tbl[t].exp_found));
      chk("tbl_multi_hold", int'(bus.multi_match), int'(tbl[t].exp_multi));
    end

    // Backpressure: address must hold while addr_ready is low.
    wait_idle();
    bus.match_vec   = 8'b0000_0110;
    bus.addr_ready  = 1'b0;
    bus.match_valid = 1'b1;
    step();
    bus.match_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_valid", int'(bus.addr_valid), 1);
      chk("bp_hold_addr", int'(bus.addr_out), 1);
      step();
    end
    chk("bp_addr1", int'(bus.addr_out), 1);
    bus.addr_ready = 1'b1;
    step();
    chk("bp_addr2", int'(bus.addr_out), 2);
    chk("bp_valid2", int'(bus.addr_valid), 1);
    step();
    chk("bp_done", int'(bus.done), 1);
    step();
    chk("bp_idle", int'(bus.match_ready), 1);

    // Reset in the middle of a full-vector drain.
    wait_idle();
    bus.match_vec   = 8'hFF;
    bus.addr_ready  = 1'b1;
    bus.match_valid = 1'b1;
    step();
    bus.match_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("rstmid_addr", int'(bus.addr_out), k);
      step();
    end
    chk("rstmid_addr4", int'(bus.addr_out), 4);
    bus.addr_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rstmid_valid", int'(bus.addr_valid), 0);
    chk("rstmid_done", int'(bus.done), 0);
    chk("rstmid_found", int'(bus.match_found), 0);
    chk("rstmid_multi", int'(bus.multi_match), 0);
    #3 rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rstmid_no_done", int'(bus.done), 0);
      chk("rstmid_ready", int'(bus.match_ready), 1);
    end
    run_vector(8'h80, 100, first, naddr, cycles);
    chk("rstmid_top_row", first, 7);

    // Randomized vectors and randomized backpressure against the model.
    for (int r = 0; r < 40; r++) begin
      run_vector(8'($urandom), $urandom_range(30, 100), first, naddr, cycles);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cam_match_resolver.md
Name: cam_match_resolver

Overview:
- Sits directly downstream of the CAM array and consumes its one-hot/multi-hot decoded match vector.
- Captures a vector and serializes every set bit into a binary row address, lowest index first, over a valid/ready stream.
- Reports match/multi-match status and a completion pulse so a controller can read out all matching rows of a search.

Parameters:
- CAM_DEPTH, 8, number of CAM rows (width of the match vector).
- ADDR_W, 3, width of the encoded address; must equal ceil(log2(CAM_DEPTH)) and be at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- match_vec  input  CAM_DEPTH  decoded match address vector from the CAM array.
- match_valid  input  1  match_vec is valid this cycle.
- match_ready  output  1  resolver can accept a vector; high only in IDLE.
- addr_out  output  ADDR_W  index of the current lowest pending match.
- addr_valid  output  1  addr_out is valid.
- addr_ready  input  1  consumer accepts addr_out.
- match_found  output  1  the last captured vector had at least one bit set.
- multi_match  output  1  the last captured vector had two or more bits set.
- done  output  1  one-cycle pulse when the current vector is fully drained.

Behaviour:
- Clock and reset: single clock `clk`; `rst` is asynchronous and active-high.
- Reset: state=IDLE; pending=0; addr_valid=0; addr_out=0; match_found=0; multi_match=0; done=0; match_ready=1 once rst deasserts.
- States:
  - IDLE: match_ready=1.
    - On match_valid: pending<=match_vec; match_found<=|match_vec; multi_match<=(popcount>=2).
    - If match_vec nonzero, go to SCAN; otherwise go to DONE.
  - SCAN: addr_valid=1; addr_out = index of the lowest set bit of pending (combinational from the pending register).
    - On addr_valid&&addr_ready: clear that bit in pending.
    - If no bits remain after the clear, go to DONE; otherwise stay in SCAN.
    - addr_out and addr_valid must hold stable while addr_ready=0.
  - DONE: done=1 for exactly this one cycle; addr_valid=0; next state is IDLE.
- Latency:
  - First address is valid one cycle after the accept.
  - Throughput is one address per cycle while addr_ready is held high.
  - An N-match vector takes N+2 cycles from accept to IDLE (accept cycle, N SCAN cycles, DONE) with addr_ready continuously high.
- Empty vector (all zeros): IDLE -> DONE -> IDLE; done pulses; match_found=0; addr_valid never asserts.
- Status hold: match_found and multi_match are registered at accept and held until the next accept; they are not cleared at DONE.
- Backpressure: match_vec and match_valid are ignored outside IDLE (match_ready=0). The upstream stage must hold its vector until accepted.
- Full vector: all CAM_DEPTH bits set yields addresses 0..CAM_DEPTH-1 in ascending order.
- Top row only: a single match at index CAM_DEPTH-1 yields addr_out=CAM_DEPTH-1 with no truncation.
- Reset mid-operation: asserting rst in SCAN immediately clears pending, addr_valid and status. No done pulse is produced and the remaining addresses are discarded.
- No combinational path from addr_ready to addr_valid or addr_out. match_ready depends on state only.

Optional Feature:
- Macro: CAM_MATCH_COUNT_EN.
- Defined:
  - Adds output match_count, width ADDR_W+1, loaded at accept with the popcount of match_vec and held until the next accept. Reset value 0.
  - Adds output remaining, width ADDR_W+1: loaded with the same popcount at accept, decremented on each addr handshake, and 0 in DONE.
- Undefined: neither port exists. No popcount beyond the >=2 detection is built; all other behaviour is identical.

Test Plan:
- Single match: match_vec=8'b0010_0000 accepted, addr_ready=1 -> next cycle addr_out=5, addr_valid=1; then done pulse; match_found=1, multi_match=0.
- Multi match: match_vec=8'b1000_1010, addr_ready=1 -> addr_out sequence 1,3,7 on consecutive cycles, then done; multi_match=1; match_ready low for 4 cycles after accept.
- Backpressure: match_vec=8'b0000_0110 with addr_ready low for 3 cycles -> addr_out stays 1 with addr_valid=1; release -> 1 then 2, then done.
- Empty: match_vec=0 -> done pulses 1 cycle after accept; addr_valid never 1; match_found=0; back in IDLE 2 cycles after accept.
- Full and reset: match_vec=8'hFF drained to addr 4, then rst asserted asynchronously -> addr_valid=0 immediately, no done pulse, match_ready=1 after rst release. A new vector 8'h80 then yields addr_out=7.
- Count (with CAM_MATCH_COUNT_EN): match_vec=8'b0101_0101 -> match_count=4; remaining steps 4,3,2,1 across the four handshakes (addrs 0,2,4,6) and reads 0 in DONE.
